// File: rtl/id_queue.sv
// Instruction decode queue between fetch and decode: in-order FIFO with a show-ahead
// head port, occupancy count, back-pressure and a sticky overflow flag.
module id_queue #(
  parameter int DECODE_ENTRY_SIZE = 96,
  parameter int DEPTH             = 8,
  parameter int ADDR_W            = 3
) (
  input  logic                         CLK,
  input  logic                         RESET,
  input  logic [DECODE_ENTRY_SIZE-1:0] decode_entry,
  input  logic                         do_write_IDQUEUE,
  output logic                         full_IDQUEUE,
  input  logic                         do_read_IDQUEUE,
  output logic [DECODE_ENTRY_SIZE-1:0] entry_out,
  output logic [31:0]                  Instr_out,
  output logic [31:0]                  PCA_out,
  output logic [31:0]                  CIA_out,
  output logic                         valid_IDQUEUE,
  input  logic                         flush_fCOM,
  input  logic                         mispredict,
  output logic [ADDR_W:0]              count_IDQUEUE,
  output logic                         overflow_err
);

  logic [DECODE_ENTRY_SIZE-1:0] r_mem [DEPTH];
  logic [ADDR_W-1:0]            r_wr_ptr;
  logic [ADDR_W-1:0]            r_rd_ptr;
  logic [ADDR_W:0]              r_count;
  logic                         r_overflow;

  logic w_clear;
  logic w_full;
  logic w_valid;
  logic w_wr_en;
  logic w_rd_en;

  // Full/valid come straight from the registered count so fetch can gate its write
  // in the same cycle; a full queue blocks a write even when a pop happens alongside.
  assign w_clear = flush_fCOM | mispredict;
  assign w_full  = (r_count == (ADDR_W+1)'(DEPTH));
  assign w_valid = (r_count != '0);
  assign w_wr_en = do_write_IDQUEUE & ~w_full & ~w_clear;
  assign w_rd_en = do_read_IDQUEUE & w_valid & ~w_clear;

  always_ff @(posedge CLK) begin
    if (RESET) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
      r_overflow <= 1'b0;
    end else begin
      if (do_write_IDQUEUE && w_full)
        r_overflow <= 1'b1;
      if (w_clear) begin
        r_wr_ptr <= '0;
        r_rd_ptr <= '0;
        r_count  <= '0;
      end else begin
        if (w_wr_en)
          r_wr_ptr <= r_wr_ptr + 1'b1;
        if (w_rd_en)
          r_rd_ptr <= r_rd_ptr + 1'b1;
        if (w_wr_en && !w_rd_en)
          r_count <= r_count + 1'b1;
        else if (w_rd_en && !w_wr_en)
          r_count <= r_count - 1'b1;
      end
    end
  end

  // Storage holds data only; stale contents are masked by valid on the read side.
  always_ff @(posedge CLK) begin
    if (w_wr_en && !RESET)
      r_mem[r_wr_ptr] <= decode_entry;
  end

  assign entry_out     = w_valid ? r_mem[r_rd_ptr] : '0;
  assign Instr_out     = entry_out[31:0];
  assign PCA_out       = entry_out[63:32];
  assign CIA_out       = entry_out[95:64];
  assign full_IDQUEUE  = w_full;
  assign valid_IDQUEUE = w_valid;
  assign count_IDQUEUE = r_count;
  assign overflow_err  = r_overflow;

endmodule

// File: tb/tb_id_queue.sv
// Directed bench for id_queue: fill/drain, overflow, wrap, simultaneous push/pop,
// flush/mispredict clear and mid-operation reset.
module tb_id_queue;

  logic        CLK = 1'b0;
  logic        RESET;
  logic [95:0] decode_entry;
  logic        do_write_IDQUEUE;
  logic        full_IDQUEUE;
  logic        do_read_IDQUEUE;
  logic [95:0] entry_out;
  logic [31:0] Instr_out;
  logic [31:0] PCA_out;
  logic [31:0] CIA_out;
  logic        valid_IDQUEUE;
  logic        flush_fCOM;
  logic        mispredict;
  logic [3:0]  count_IDQUEUE;
  logic        overflow_err;

  int total = 0;
  int bad   = 0;

  id_queue #(.DECODE_ENTRY_SIZE(96), .DEPTH(8), .ADDR_W(3)) dut (
    .CLK              (CLK),
    .RESET            (RESET),
    .decode_entry     (decode_entry),
    .do_write_IDQUEUE (do_write_IDQUEUE),
    .full_IDQUEUE     (full_IDQUEUE),
    .do_read_IDQUEUE  (do_read_IDQUEUE),
    .entry_out        (entry_out),
    .Instr_out        (Instr_out),
    .PCA_out          (PCA_out),
    .CIA_out          (CIA_out),
    .valid_IDQUEUE    (valid_IDQUEUE),
    .flush_fCOM       (flush_fCOM),
    .mispredict       (mispredict),
    .count_IDQUEUE    (count_IDQUEUE),
    .overflow_err     (overflow_err)
  );

  always #5 CLK = ~CLK;

  // Entry k: CIA=4k, PCA=4k+4, Instr=0x24020001+k (entry 0 is the first vector).
  function automatic logic [95:0] mk(input int k);
    logic [31:0] cia, pca, ins;
    cia = 32'(k * 4);
    pca = 32'(k * 4 + 4);
    ins = 32'h24020001 + 32'(k);
    return {cia, pca, ins};
  endfunction

  task automatic chk(input string tag, input logic [95:0] obs, input logic [95:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One clock: drive inputs, take the edge, settle #1 after it, then idle inputs.
  task automatic step(input logic wr, input logic [95:0] d, input logic rd,
                      input logic mp, input logic fl, input logic rst);
    do_write_IDQUEUE = wr;
    decode_entry     = d;
    do_read_IDQUEUE  = rd;
    mispredict       = mp;
    flush_fCOM       = fl;
    RESET            = rst;
    @(posedge CLK);
    #1;
    do_write_IDQUEUE = 1'b0;
    do_read_IDQUEUE  = 1'b0;
    mispredict       = 1'b0;
    flush_fCOM       = 1'b0;
    RESET            = 1'b0;
    decode_entry     = '0;
  endtask

  task automatic push(input int k);
    step(1'b1, mk(k), 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic pop_chk(input string tag, input int k);
    chk(tag, entry_out, mk(k));
    step(1'b0, '0, 1'b1, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    RESET = 1'b1; decode_entry = '0; do_write_IDQUEUE = 1'b0; do_read_IDQUEUE = 1'b0;
    mispredict = 1'b0; flush_fCOM = 1'b0;
    step(1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b1);
    step(1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b1);
    chk("rst_count", 96'(count_IDQUEUE), 96'd0);
    chk("rst_full", 96'(full_IDQUEUE), 96'd0);
    chk("rst_valid", 96'(valid_IDQUEUE), 96'd0);
    chk("rst_entry", entry_out, 96'd0);
    chk("rst_ovf", 96'(overflow_err), 96'd0);

    // 1: three writes, show-ahead head, in-order pops
    for (int i = 0; i < 3; i++) push(i);
    chk("t1_count", 96'(count_IDQUEUE), 96'd3);
    chk("t1_valid", 96'(valid_IDQUEUE), 96'd1);
    chk("t1_entry", entry_out, {32'h0, 32'h4, 32'h24020001});
    chk("t1_instr", 96'(Instr_out), 96'h24020001);
    chk("t1_pca", 96'(PCA_out), 96'h4);
    chk("t1_cia", 96'(CIA_out), 96'h0);
    for (int i = 0; i < 3; i++) pop_chk("t1_pop", i);
    chk("t1_valid_end", 96'(valid_IDQUEUE), 96'd0);
    chk("t1_entry_end", entry_out, 96'd0);
    chk("t1_count_end", 96'(count_IDQUEUE), 96'd0);

    // 2: fill, overflow, drain across pointer wrap (pointers start at 3)
    for (int i = 0; i < 7; i++) push(10 + i);
    chk("t2_notfull7", 96'(full_IDQUEUE), 96'd0);
    push(17);
    chk("t2_full", 96'(full_IDQUEUE), 96'd1);
    chk("t2_count8", 96'(count_IDQUEUE), 96'd8);
    chk("t2_ovf_before", 96'(overflow_err), 96'd0);
    push(99);
    chk("t2_count_ovf", 96'(count_IDQUEUE), 96'd8);
    chk("t2_ovf", 96'(overflow_err), 96'd1);
    for (int i = 0; i < 8; i++) pop_chk("t2_drain", 10 + i);
    chk("t2_empty", 96'(valid_IDQUEUE), 96'd0);

    // 3: steady occupancy of 4 with simultaneous push/pop
    for (int i = 0; i < 4; i++) push(20 + i);
    for (int i = 0; i < 10; i++) begin
      chk("t3_head", entry_out, mk(20 + i));
      step(1'b1, mk(24 + i), 1'b1, 1'b0, 1'b0, 1'b0);
      chk("t3_count", 96'(count_IDQUEUE), 96'd4);
    end
    for (int i = 0; i < 4; i++) pop_chk("t3_drain", 30 + i);
    chk("t3_empty", 96'(count_IDQUEUE), 96'd0);

    // 4: mispredict and flush discard contents and the same-cycle write
    for (int i = 0; i < 5; i++) push(40 + i);
    chk("t4_count5", 96'(count_IDQUEUE), 96'd5);
    step(1'b1, mk(45), 1'b0, 1'b1, 1'b0, 1'b0);
    chk("t4_mp_count", 96'(count_IDQUEUE), 96'd0);
    chk("t4_mp_valid", 96'(valid_IDQUEUE), 96'd0);
    chk("t4_mp_entry", entry_out, 96'd0);
    push(46);
    chk("t4_mp_after", entry_out, mk(46));
    chk("t4_mp_cnt1", 96'(count_IDQUEUE), 96'd1);
    for (int i = 0; i < 4; i++) push(50 + i);
    chk("t4_count5b", 96'(count_IDQUEUE), 96'd5);
    step(1'b1, mk(55), 1'b1, 1'b0, 1'b1, 1'b0);
    chk("t4_fl_count", 96'(count_IDQUEUE), 96'd0);
    chk("t4_fl_valid", 96'(valid_IDQUEUE), 96'd0);
    push(56);
    chk("t4_fl_after", entry_out, mk(56));
    pop_chk("t4_fl_pop", 56);

    // 5: full + push + pop: only the pop happens
    for (int i = 0; i < 8; i++) push(60 + i);
    chk("t5_full", 96'(full_IDQUEUE), 96'd1);
    step(1'b1, mk(68), 1'b1, 1'b0, 1'b0, 1'b0);
    chk("t5_count7", 96'(count_IDQUEUE), 96'd7);
    chk("t5_notfull", 96'(full_IDQUEUE), 96'd0);
    for (int i = 0; i < 7; i++) pop_chk("t5_drain", 61 + i);
    chk("t5_absent", 96'(valid_IDQUEUE), 96'd0);

    // 6: reset mid-operation, then pop while empty
    for (int i = 0; i < 6; i++) push(70 + i);
    chk("t6_count6", 96'(count_IDQUEUE), 96'd6);
    chk("t6_ovf_sticky", 96'(overflow_err), 96'd1);
    step(1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b1);
    chk("t6_count", 96'(count_IDQUEUE), 96'd0);
    chk("t6_full", 96'(full_IDQUEUE), 96'd0);
    chk("t6_valid", 96'(valid_IDQUEUE), 96'd0);
    chk("t6_ovf", 96'(overflow_err), 96'd0);
    step(1'b0, '0, 1'b1, 1'b0, 1'b0, 1'b0);
    chk("t6_pop_count", 96'(count_IDQUEUE), 96'd0);
    chk("t6_pop_valid", 96'(valid_IDQUEUE), 96'd0);
    chk("t6_pop_ovf", 96'(overflow_err), 96'd0);
    push(80);
    chk("t6_after", entry_out, mk(80));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
